// File: rtl/tx_interrupt_ctrl.sv
// TX interrupt sequencer: latches masked event strobes, coalesces them by count
// or timeout, and holds a level interrupt until acknowledged.
// Optional ack holdoff window enabled by defining TX_INTERRUPT_CTRL_HOLDOFF_EN.
module tx_interrupt_ctrl #(
  parameter int NUM_SRC   = 5,
  parameter int CNT_WIDTH = 8,
  parameter int TMO_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   event_in,
  input  logic [NUM_SRC-1:0]   src_en,
  input  logic                 itrpt_en,
  input  logic [CNT_WIDTH-1:0] coalesce_thr,
  input  logic [TMO_WIDTH-1:0] timeout_cycles,
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
  input  logic [15:0]          holdoff_cycles,
`endif
  input  logic                 itrpt_ack,
  output logic                 tx_itrpt,
  output logic [NUM_SRC-1:0]   pending,
  output logic [15:0]          itrpt_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TMO_WIDTH-1:0] TMR_ONE = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [TMO_WIDTH-1:0] sat_inc_tmr(input logic [TMO_WIDTH-1:0] v);
    return (&v) ? v : v + TMR_ONE;
  endfunction

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next;
  logic [TMO_WIDTH-1:0]   tmr, tmr_next;
  logic [NUM_SRC-1:0]     masked;
  logic                   hit;
  logic                   thr_le1;
  logic [CNT_WIDTH-1:0]   thr_eff;
  logic [CNT_WIDTH:0]     cnt_plus1;
  logic                   thr_reached;
  logic                   tmo_reached;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
  logic [15:0]            hld, hld_next;
  logic [CNT_WIDTH-1:0]   cnt_fin;
`endif

  assign masked      = event_in & src_en;
  assign hit         = |masked;
  assign thr_le1     = (coalesce_thr <= CNT_ONE);
  assign thr_eff     = thr_le1 ? CNT_ONE : coalesce_thr;
  assign cnt_plus1   = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // A lowered threshold already met by the stored count fires without a new hit;
  // this also re-arms the immediate mode after an ack that collided with a hit.
  assign thr_reached = (hit && (cnt_plus1 >= {1'b0, coalesce_thr})) || (cnt >= thr_eff);
  assign tmo_reached = (timeout_cycles != '0) && (tmr == timeout_cycles);
  assign state_dbg   = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tmr_next   = tmr;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
    hld_next   = hld;
    cnt_fin    = hit ? sat_inc_cnt(cnt) : cnt;
`endif
    if (!itrpt_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      tmr_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          tmr_next = '0;
          if (hit) begin
            if (thr_le1) begin
              state_next = ASSERT;
            end else begin
              state_next = COLLECT;
              cnt_next   = CNT_ONE;
              tmr_next   = TMR_ONE;
            end
          end
        end
        COLLECT: begin
          tmr_next = sat_inc_tmr(tmr);
          if (hit) cnt_next = sat_inc_cnt(cnt);
          if (thr_reached || tmo_reached) state_next = ASSERT;
        end
        ASSERT: begin
          if (itrpt_ack) begin
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
            if (holdoff_cycles != 16'd0) begin
              state_next = HOLDOFF;
              hld_next   = 16'd1;
              cnt_next   = hit ? CNT_ONE : '0;
              tmr_next   = '0;
            end else
`endif
            if (hit) begin
              state_next = COLLECT;
              cnt_next   = CNT_ONE;
              tmr_next   = TMR_ONE;
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
              tmr_next   = '0;
            end
          end
        end
        HOLDOFF: begin
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
          cnt_next = cnt_fin;
          if (hld >= holdoff_cycles) begin
            if (cnt_fin >= thr_eff) begin
              state_next = ASSERT;
            end else if (cnt_fin != '0) begin
              state_next = COLLECT;
              tmr_next   = TMR_ONE;
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
              tmr_next   = '0;
            end
          end else begin
            hld_next = hld + 16'd1;
          end
`else
          state_next = IDLE;
          cnt_next   = '0;
          tmr_next   = '0;
`endif
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          tmr_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      tx_itrpt    <= 1'b0;
      pending     <= '0;
      itrpt_count <= 16'd0;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
      hld         <= 16'd0;
`endif
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      tmr      <= tmr_next;
      tx_itrpt <= (state_next == ASSERT);
      // Events arriving in the ack cycle survive the clear.
      pending  <= itrpt_ack ? masked : (pending | masked);
      if ((state_next == ASSERT) && (state != ASSERT)) itrpt_count <= itrpt_count + 16'd1;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
      hld      <= hld_next;
`endif
    end
  end

endmodule

// File: tb/tb_tx_interrupt_ctrl.sv
// Bench for tx_interrupt_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-based reference model.
module tb_tx_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  event_in;
  logic [4:0]  src_en;
  logic        itrpt_en;
  logic [7:0]  coalesce_thr;
  logic [15:0] timeout_cycles;
  logic        itrpt_ack;
  logic        tx_itrpt;
  logic [4:0]  pending;
  logic [15:0] itrpt_count;
  logic [1:0]  state_dbg;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
  logic [15:0] holdoff_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: interrupt raised / window open, first-event cycle, hit cycles in window
  bit          m_asrt;
  bit          m_col;
  logic [4:0]  m_pend;
  int          m_wstart;
  int          m_whits;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  tx_interrupt_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .event_in       (event_in),
    .src_en         (src_en),
    .itrpt_en       (itrpt_en),
    .coalesce_thr   (coalesce_thr),
    .timeout_cycles (timeout_cycles),
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
    .holdoff_cycles (holdoff_cycles),
`endif
    .itrpt_ack      (itrpt_ack),
    .tx_itrpt       (tx_itrpt),
    .pending        (pending),
    .itrpt_count    (itrpt_count),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0] m;
    bit         h;
    int         te;
    bit         was;
    m  = event_in & src_en;
    h  = |m;
    te = (coalesce_thr <= 8'd1) ? 1 : int'(coalesce_thr);
    if (rst) begin
      m_asrt = 0; m_col = 0; m_pend = '0; m_count = '0; m_whits = 0;
      return;
    end
    m_pend = itrpt_ack ? m : (m_pend | m);
    was    = m_asrt;
    if (!itrpt_en) begin
      m_asrt = 0;
      m_col  = 0;
    end else if (m_asrt) begin
      if (itrpt_ack) begin
        m_asrt = 0;
        if (h) begin m_col = 1; m_wstart = cyc; m_whits = 1; end
      end
    end else if (m_col) begin
      if ((m_whits + int'(h) >= te) ||
          (timeout_cycles != 16'd0 && (cyc - m_wstart) == int'(timeout_cycles))) begin
        m_asrt = 1;
        m_col  = 0;
      end else begin
        m_whits += int'(h);
      end
    end else if (h) begin
      if (te == 1) m_asrt = 1;
      else begin m_col = 1; m_wstart = cyc; m_whits = 1; end
    end
    if (m_asrt && !was) m_count = m_count + 16'd1;
  endtask

  task automatic step(input logic [4:0] ev, input logic ack, input bit mchk);
    event_in  = ev;
    itrpt_ack = ack;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    if (mchk) begin
      check("tx_itrpt", 32'(tx_itrpt), 32'(m_asrt));
      check("pending", 32'(pending), 32'(m_pend));
      check("itrpt_count", 32'(itrpt_count), 32'(m_count));
      check("state_dbg", 32'(state_dbg), m_asrt ? 32'd2 : (m_col ? 32'd1 : 32'd0));
    end
    event_in  = '0;
    itrpt_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] c0;
    logic [4:0]  ev;
    rst = 1'b1; event_in = '0; src_en = 5'b11111; itrpt_en = 1'b1;
    coalesce_thr = 8'd1; timeout_cycles = 16'd0; itrpt_ack = 1'b0;
`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
    holdoff_cycles = 16'd0;
`endif
    step(5'b0, 1'b0, 1'b1);
    step(5'b0, 1'b0, 1'b1);
    check("rst_tx", 32'(tx_itrpt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    idle(3);

    // Immediate mode
    step(5'b00010, 1'b0, 1'b1);
    check("imm_tx", 32'(tx_itrpt), 32'd1);
    check("imm_pend", 32'(pending), 32'h02);
    check("imm_count", 32'(itrpt_count), 32'd1);
    idle(8);
    check("imm_hold", 32'(tx_itrpt), 32'd1);
    step(5'b0, 1'b1, 1'b1);
    check("imm_ack_tx", 32'(tx_itrpt), 32'd0);
    check("imm_ack_pend", 32'(pending), 32'd0);

    // Count coalescing, threshold 4
    coalesce_thr = 8'd4;
    step(5'b00001, 1'b0, 1'b1); idle(1);
    step(5'b00001, 1'b0, 1'b1); idle(2);
    step(5'b00001, 1'b0, 1'b1); idle(2);
    check("coal_low", 32'(tx_itrpt), 32'd0);
    step(5'b00001, 1'b0, 1'b1);
    check("coal_high", 32'(tx_itrpt), 32'd1);
    step(5'b0, 1'b1, 1'b1);
    step(5'b00001, 1'b0, 1'b1); idle(1);
    step(5'b00001, 1'b0, 1'b1); idle(1);
    step(5'b00001, 1'b0, 1'b1); idle(20);
    check("coal_three", 32'(tx_itrpt), 32'd0);
    itrpt_en = 1'b0; step(5'b0, 1'b1, 1'b1); itrpt_en = 1'b1;

    // Timeout 5 with threshold 8
    coalesce_thr = 8'd8; timeout_cycles = 16'd5;
    step(5'b10000, 1'b0, 1'b1);
    idle(4);
    check("tmo_low", 32'(tx_itrpt), 32'd0);
    idle(1);
    check("tmo_high", 32'(tx_itrpt), 32'd1);
    check("tmo_state", 32'(state_dbg), 32'd2);
    step(5'b0, 1'b1, 1'b1);

    // Mask and global enable
    coalesce_thr = 8'd1; timeout_cycles = 16'd0; src_en = 5'b00100;
    step(5'b00011, 1'b0, 1'b1); idle(1);
    check("mask_tx", 32'(tx_itrpt), 32'd0);
    check("mask_pend", 32'(pending), 32'd0);
    itrpt_en = 1'b0;
    step(5'b00100, 1'b0, 1'b1); idle(2);
    check("dis_pend", 32'(pending), 32'h04);
    check("dis_tx", 32'(tx_itrpt), 32'd0);
    itrpt_en = 1'b1; idle(3);
    check("reen_tx", 32'(tx_itrpt), 32'd0);

    // Ack colliding with a new hit in immediate mode
    src_en = 5'b11111;
    step(5'b0, 1'b1, 1'b1);
    step(5'b00001, 1'b0, 1'b1);
    c0 = itrpt_count;
    step(5'b01000, 1'b1, 1'b1);
    check("coll_drop", 32'(tx_itrpt), 32'd0);
    check("coll_pend", 32'(pending), 32'h08);
    step(5'b0, 1'b0, 1'b1);
    check("coll_rise", 32'(tx_itrpt), 32'd1);
    check("coll_count", 32'(itrpt_count), 32'(c0 + 16'd1));

    // Reset during ASSERT after seven interrupts
    rst = 1'b1; step(5'b0, 1'b0, 1'b1); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(5'b00100, 1'b0, 1'b1);
      step(5'b0, 1'b1, 1'b1);
    end
    step(5'b10001, 1'b0, 1'b1);
    check("pre_rst_count", 32'(itrpt_count), 32'd7);
    check("pre_rst_pend", 32'(pending), 32'h11);
    rst = 1'b1; step(5'b0, 1'b0, 1'b1); rst = 1'b0;
    check("mid_rst_tx", 32'(tx_itrpt), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    check("mid_rst_count", 32'(itrpt_count), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);

`ifdef TX_INTERRUPT_CTRL_HOLDOFF_EN
    holdoff_cycles = 16'd3;
    step(5'b00001, 1'b0, 1'b0);
    step(5'b0, 1'b1, 1'b0);
    check("hold_state", 32'(state_dbg), 32'd3);
    check("hold_tx", 32'(tx_itrpt), 32'd0);
    step(5'b0, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b0, 1'b0, 1'b0);
    check("hold_reassert", 32'(tx_itrpt), 32'd1);
    holdoff_cycles = 16'd0;
    rst = 1'b1; step(5'b0, 1'b0, 1'b1); rst = 1'b0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        coalesce_thr   = 8'($urandom_range(0, 5));
        timeout_cycles = 16'($urandom_range(0, 8));
        src_en         = 5'($urandom);
      end
      itrpt_en = ($urandom_range(0, 40) != 0);
      rst      = ($urandom_range(0, 300) == 0);
      ev       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      step(ev, ($urandom_range(0, 7) == 0), 1'b1);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
